bcd_operand_entry: RTL and testbench
====================================

# bcd_operand_entry

Upstream operand-entry stage for the two-digit BCD adder/display path. It turns three push buttons and an operand-select switch into the four BCD operand digits the adder consumes: ones1, tens1, ones2 and tens2. Each button is synchronised and debounced, then edge-detected, so one physical press changes a digit by exactly one step. Every output digit is registered and always holds a value from 0 to 9.

## Interface
- DB_CYCLES, default 1000000: number of consecutive cycles an input must hold a new level before it is accepted. At 100 MHz this is 10 ms. Benches use 4.
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- btn_ones  in  1  raw push button; increments the ones digit of the selected operand.
- btn_tens  in  1  raw push button; increments the tens digit of the selected operand.
- btn_clr  in  1  raw push button; clears both operands.
- sel  in  1  raw slide switch; 0 selects operand 1, 1 selects operand 2.
- ones1  out  4  operand 1 ones digit, BCD.
- tens1  out  4  operand 1 tens digit, BCD.
- ones2  out  4  operand 2 ones digit, BCD.
- tens2  out  4  operand 2 tens digit, BCD.
- press  out  1  one-cycle pulse on every accepted button action.

## Operation
- **Synchronisers:** each of btn_ones, btn_tens, btn_clr and sel passes through a 2-FF synchroniser. sel is used after synchronisation only; it is not debounced.
- **Debouncer, one per button:**
  - Each button has a stable register and a counter of width $clog2(DB_CYCLES).
  - While the synced level equals stable, the counter is held at 0.
  - While the synced level differs from stable, the counter increments each cycle.
  - When the counter equals DB_CYCLES-1 and the levels still differ, stable takes the synced level and the counter returns to 0.
  - Any bounce that returns the synced level to stable resets the counter.
- **Edge detect:** rise = stable & ~stable_d, where stable_d is stable delayed by one register. A release (1→0) produces no action.
- **Digit update,** registered, applied to the operand selected by the synced sel at that edge:
  - rise_clr: ones1, tens1, ones2 and tens2 all go to 0. Clear has priority over any increment in the same cycle.
  - rise_ones: the selected ones digit goes to ones+1, and 9 wraps to 0. There is no carry into tens.
  - rise_tens: the selected tens digit goes to tens+1, and 9 wraps to 0.
  - rise_ones and rise_tens in the same cycle, without clear: both digits of the selected operand increment.
  - The unselected operand is never modified except by clear.
- **press** is registered. It is 1 on the edge where any rise is acted on, and 0 otherwise.
- **Reset values:** all digit outputs are 0 and press is 0. Synchronisers, stable, stable_d and the counters are all 0.
- **Reset mid-operation:** a press in progress is discarded. After rst deasserts, a button that is still held reads as a new press once it has been stable for DB_CYCLES cycles.

## Timing
- Let edge 0 be the first edge that samples a raw button high, with the button held high thereafter:
  - synced level high after edge 1;
  - counting on edges 2 through DB_CYCLES+1;
  - stable high after edge DB_CYCLES+1;
  - digit and press change at edge DB_CYCLES+2.
- Press latency is therefore DB_CYCLES+2 edges, measured from edge 0. Release latency is the same, but a release has no visible effect.
- A pulse or glitch shorter than DB_CYCLES synced cycles produces no action.
- Holding a button does not auto-repeat. At most one action occurs per stable press.
- sel is sampled at the update edge. A change to sel is visible 2 edges after it is sampled and affects only later updates.
- press is high for exactly one cycle per accepted rise. Simultaneous rises produce a single press cycle.

## Test plan
All scenarios use DB_CYCLES=4.
- **Reset:** hold rst for 3 cycles with buttons idle, then release. All digits read 0 and press is 0. Assert rst asynchronously mid-cycle and check the outputs clear immediately.
- **Single press:** sel=0, hold btn_ones high for 20 cycles. ones1 goes 0→1 at edge 6 after the first sample, press pulses for exactly 1 cycle, and tens1, ones2 and tens2 are unchanged.
- **Bounce:** sel=1, toggle btn_tens with the pattern 1,1,0,1,1,1,0 and then hold it high. Exactly one increment occurs: tens2 becomes 1 at DB_CYCLES+2 edges after the final rising sample, with a single press pulse.
- **Wrap:** sel=0, apply 10 clean presses to btn_ones. ones1 steps 1..9 and then returns to 0, tens1 stays 0, and 10 press pulses are seen.
- **Simultaneous and priority:** set ones1=3, tens1=5, ones2=7. Press btn_ones and btn_tens on the same cycle with sel=0; the result is ones1=4, tens1=6 with one press pulse. Then press btn_clr together with btn_ones; all four digits become 0.
- **Glitch rejection:** drive btn_clr high for 3 cycles only. The digits are unchanged and press stays 0.

Source files
------------

// File: rtl/bcd_operand_entry.sv
// Operand-entry stage for the two-digit BCD adder: synchronises, debounces and
// edge-detects three push buttons and steps four registered BCD digits.
module bcd_operand_entry #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ones,
  input  logic       btn_tens,
  input  logic       btn_clr,
  input  logic       sel,
  output logic [3:0] ones1,
  output logic [3:0] tens1,
  output logic [3:0] ones2,
  output logic [3:0] tens2,
  output logic       press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  // Bit order for the synchroniser vectors: {sel, clr, tens, ones}
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [2:0]    stable;
  logic [2:0]    stable_d;
  logic [2:0]    rise;
  logic [CW-1:0] cnt [3];
  logic          sel_s;

  assign sel_s = sync2[3];
  assign rise  = stable & ~stable_d;

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {sel, btn_clr, btn_tens, btn_ones};
      sync2 <= sync1;
    end
  end

  // A new level is accepted only after DB_CYCLES consecutive differing cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable   <= '0;
      stable_d <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      stable_d <= stable;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Clear wins over increments; the unselected operand is left untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones1 <= '0;
      tens1 <= '0;
      ones2 <= '0;
      tens2 <= '0;
      press <= 1'b0;
    end else begin
      press <= |rise;
      if (rise[2]) begin
        ones1 <= '0;
        tens1 <= '0;
        ones2 <= '0;
        tens2 <= '0;
      end else if (!sel_s) begin
        if (rise[0]) ones1 <= bcd_inc(ones1);
        if (rise[1]) tens1 <= bcd_inc(tens1);
      end else begin
        if (rise[0]) ones2 <= bcd_inc(ones2);
        if (rise[1]) tens2 <= bcd_inc(tens2);
      end
    end
  end

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Scoreboard bench for bcd_operand_entry: each expected press result is queued
// by the stimulus and popped by a monitor whenever the DUT pulses press.
module tb_bcd_operand_entry;

  logic       clk;
  logic       rst;
  logic       btn_ones;
  logic       btn_tens;
  logic       btn_clr;
  logic       sel;
  logic [3:0] ones1;
  logic [3:0] tens1;
  logic [3:0] ones2;
  logic [3:0] tens2;
  logic       press;

  int vectors     = 0;
  int miscompares = 0;
  int press_seen  = 0;
  int press_exp   = 0;

  logic [15:0] exp_q[$];
  logic [3:0]  m_o1 = 0, m_t1 = 0, m_o2 = 0, m_t2 = 0;
  logic        m_sel = 0;

  bcd_operand_entry #(.DB_CYCLES(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_ones (btn_ones),
    .btn_tens (btn_tens),
    .btn_clr  (btn_clr),
    .sel      (sel),
    .ones1    (ones1),
    .tens1    (tens1),
    .ones2    (ones2),
    .tens2    (tens2),
    .press    (press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: every press pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && press) begin
      press_seen++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_press got=%h_%h_%h_%h with empty scoreboard",
                 ones1, tens1, ones2, tens2);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({ones1, tens1, ones2, tens2} !== e)
          begin
            miscompares++;
            $display("[TB] FAIL press_digits got o1_t1_o2_t2=%h_%h_%h_%h expected=%h_%h_%h_%h",
                     ones1, tens1, ones2, tens2, e[15:12], e[11:8], e[7:4], e[3:0]);
          end
      end
    end
  end

  function automatic logic [3:0] inc9(input logic [3:0] d);
    return (d == 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  task automatic check_output(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Model of one accepted action; btns = {clr, tens, ones}
  task automatic model_update(input logic [2:0] btns);
    if (btns[2]) begin
      m_o1 = 0; m_t1 = 0; m_o2 = 0; m_t2 = 0;
    end else if (!m_sel) begin
      if (btns[0]) m_o1 = inc9(m_o1);
      if (btns[1]) m_t1 = inc9(m_t1);
    end else begin
      if (btns[0]) m_o2 = inc9(m_o2);
      if (btns[1]) m_t2 = inc9(m_t2);
    end
    exp_q.push_back({m_o1, m_t1, m_o2, m_t2});
    press_exp++;
  endtask

  task automatic apply_stimulus(input logic [2:0] btns, input int hold);
    @(negedge clk);
    {btn_clr, btn_tens, btn_ones} = btns;
    repeat (hold) @(negedge clk);
    {btn_clr, btn_tens, btn_ones} = 3'b000;
    repeat (12) @(negedge clk);
  endtask

  task automatic set_sel(input logic v);
    @(negedge clk);
    sel   = v;
    m_sel = v;
    repeat (4) @(negedge clk);
  endtask

  function automatic logic [15:0] model_digits();
    return {m_o1, m_t1, m_o2, m_t2};
  endfunction

  initial begin
    logic [6:0] bounce;
    bounce = 7'b1101110;
    rst = 1'b1; btn_ones = 0; btn_tens = 0; btn_clr = 0; sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_output("reset_digits", {ones1, tens1, ones2, tens2}, 16'h0000);
    check_output("reset_press", {15'd0, press}, 16'd0);

    // Single press with edge-exact latency
    set_sel(1'b0);
    model_update(3'b001);
    btn_ones = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_output("single_before_edge6", {ones1, tens1, ones2, tens2}, 16'h0000);
    check_output("single_press_low_edge5", {15'd0, press}, 16'd0);
    @(negedge clk);
    check_output("single_at_edge6", {ones1, tens1, ones2, tens2}, 16'h1000);
    check_output("single_press_high", {15'd0, press}, 16'd1);
    @(negedge clk);
    check_output("single_press_one_cycle", {15'd0, press}, 16'd0);
    repeat (12) @(negedge clk);
    btn_ones = 1'b0;
    repeat (12) @(negedge clk);
    check_output("single_no_repeat", {ones1, tens1, ones2, tens2}, 16'h1000);

    // Bounce on tens with operand 2 selected
    set_sel(1'b1);
    for (int i = 0; i < 7; i++) begin
      btn_tens = bounce[6 - i];
      @(negedge clk);
    end
    model_update(3'b010);
    btn_tens = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_output("bounce_before", {ones1, tens1, ones2, tens2}, 16'h1000);
    @(negedge clk);
    check_output("bounce_after", {ones1, tens1, ones2, tens2}, 16'h1001);
    repeat (10) @(negedge clk);
    btn_tens = 1'b0;
    repeat (12) @(negedge clk);

    // Clear then wrap through ten presses
    set_sel(1'b0);
    model_update(3'b100);
    apply_stimulus(3'b100, 8);
    check_output("clear_all", {ones1, tens1, ones2, tens2}, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      model_update(3'b001);
      apply_stimulus(3'b001, 8);
    end
    check_output("wrap_result", {ones1, tens1, ones2, tens2}, 16'h0000);

    // Preset ones1=3, tens1=5, ones2=7
    for (int i = 0; i < 3; i++) begin model_update(3'b001); apply_stimulus(3'b001, 8); end
    for (int i = 0; i < 5; i++) begin model_update(3'b010); apply_stimulus(3'b010, 8); end
    set_sel(1'b1);
    for (int i = 0; i < 7; i++) begin model_update(3'b001); apply_stimulus(3'b001, 8); end
    set_sel(1'b0);
    check_output("preset", {ones1, tens1, ones2, tens2}, 16'h3570);
    model_update(3'b011);
    apply_stimulus(3'b011, 8);
    check_output("simultaneous", {ones1, tens1, ones2, tens2}, 16'h4670);
    model_update(3'b101);
    apply_stimulus(3'b101, 8);
    check_output("clear_priority", {ones1, tens1, ones2, tens2}, 16'h0000);

    // Glitch on clear must be ignored
    model_update(3'b001);
    apply_stimulus(3'b001, 8);
    @(negedge clk);
    btn_clr = 1'b1;
    repeat (3) @(negedge clk);
    btn_clr = 1'b0;
    repeat (20) @(negedge clk);
    check_output("glitch_rejected", {ones1, tens1, ones2, tens2}, model_digits());

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_output("async_reset_digits", {ones1, tens1, ones2, tens2}, 16'h0000);
    check_output("async_reset_press", {15'd0, press}, 16'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check_output("after_reset", {ones1, tens1, ones2, tens2}, 16'h0000);

    check_output("press_count", 16'(press_seen), 16'(press_exp));
    check_output("scoreboard_drained", 16'(exp_q.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
